// File: rtl/fifo_reader_pkg.sv
// Shared constants for the FIFO consumer engine: one-hot state encoding and defaults.
package fifo_reader_pkg;

  localparam int unsigned DataWDefault   = 8;
  localparam int unsigned TimeoutDefault = 255;
  localparam int unsigned TimerW         = 8;

  localparam int unsigned IdleBit = 0;
  localparam int unsigned ReqBit  = 1;
  localparam int unsigned WaitBit = 2;
  localparam int unsigned HoldBit = 3;

  typedef logic [3:0] state_t;

  localparam state_t StIdle = 4'b0001;
  localparam state_t StReq  = 4'b0010;
  localparam state_t StWait = 4'b0100;
  localparam state_t StHold = 4'b1000;

endpackage

// File: rtl/fifo_reader_wait_timer.sv
// Saturating wait counter; o_done pulses for one cycle when the count first reaches TIMEOUT.
module wait_timer
  import fifo_reader_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_done
);

  localparam logic [TimerW-1:0] Limit = TimerW'(TIMEOUT);

  logic [TimerW-1:0] r_count;
  logic              r_at_limit;
  logic              w_at_limit;

  assign w_at_limit = (r_count == Limit);
  // Only the first cycle at the limit fires, so a saturated count cannot re-trigger.
  assign o_done     = w_at_limit & ~r_at_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_at_limit <= 1'b0;
    end else begin
      if (i_clear) begin
        r_count <= '0;
      end else if (i_enable && !w_at_limit) begin
        r_count <= r_count + 1'b1;
      end
      r_at_limit <= w_at_limit;
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Pops bytes from the FIFO one at a time and hands them to the PicoBlaze via valid/ack.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_W  = DataWDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic              fifo_threshold,
  input  logic              fifo_underflow,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              irq,
  input  logic              irq_ack,
  output logic              err
);

  state_t              r_state;
  state_t              w_state_d;
  logic [DATA_W-1:0]   r_rx_data;
  logic                r_rx_valid;
  logic                r_irq;
  logic                r_err;
  logic                w_abort;
  logic                w_timer_done;

  // A pop is dropped if the FIFO drained between IDLE and REQ.
  assign w_abort  = r_state[ReqBit] & fifo_empty;
  assign fifo_rd  = r_state[ReqBit] & ~fifo_empty;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign irq      = r_irq;
  assign err      = r_err;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (!fifo_empty) w_state_d = StReq;
      StReq:   w_state_d = fifo_empty ? StIdle : StWait;
      StWait:  w_state_d = StHold;
      StHold:  if (rx_ack) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (~r_rx_valid),
    .i_enable (r_state[HoldBit] & ~rx_ack),
    .o_done   (w_timer_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_irq      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (r_state[WaitBit]) begin
        r_rx_data  <= fifo_data;
        r_rx_valid <= 1'b1;
      end else if (r_state[HoldBit] && rx_ack) begin
        r_rx_valid <= 1'b0;
      end
      // Set beats acknowledge when both land in the same cycle.
      if (fifo_threshold || (w_timer_done && r_rx_valid)) begin
        r_irq <= 1'b1;
      end else if (irq_ack) begin
        r_irq <= 1'b0;
      end
      if (fifo_underflow || w_abort) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a small behavioural FIFO on its read side.
module tb_fifo_reader;
  import fifo_reader_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic       fifo_threshold;
  logic       fifo_underflow;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       irq;
  logic       irq_ack;
  logic       err;

  logic [7:0] mem [0:31];
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  int         rd_pulses = 0;
  logic       empty_force;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_cnt == rd_cnt) || empty_force;

  always @(posedge clk) begin
    if (fifo_rd === 1'b1) begin
      rd_pulses <= rd_pulses + 1;
      if (wr_cnt != rd_cnt) begin
        fifo_data <= mem[rd_cnt[4:0]];
        rd_cnt    <= rd_cnt + 1;
      end
    end
  end

  fifo_reader #(
    .DATA_W  (8),
    .TIMEOUT (10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_empty     (fifo_empty),
    .fifo_threshold (fifo_threshold),
    .fifo_underflow (fifo_underflow),
    .fifo_data      (fifo_data),
    .fifo_rd        (fifo_rd),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ack         (rx_ack),
    .irq            (irq),
    .irq_ack        (irq_ack),
    .err            (err)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_cnt[4:0]] = b;
    wr_cnt = wr_cnt + 1;
  endtask

  task automatic ack_byte();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (fifo_rd !== 1'b0) begin failures++; $display("FAIL rst_fifo_rd got=%0h exp=0", fifo_rd); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rst_rx_valid got=%0h exp=0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rst_rx_data got=%0h exp=0", rx_data); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%0h exp=0", irq); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0h exp=0", err); end
    rst = 1'b0;
    tick();
    // Stray ack with nothing held must be ignored.
    ack_byte();
    tick();
    checks++; if (dut.r_state !== StIdle) begin failures++; $display("FAIL stray_ack_state got=%0h exp=%0h", dut.r_state, StIdle); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL stray_ack_valid got=%0h exp=0", rx_valid); end
  endtask

  task automatic test_single();
    push(8'hA5);
    tick();
    checks++; if (fifo_rd !== 1'b1) begin failures++; $display("FAIL single_rd_c1 got=%0h exp=1", fifo_rd); end
    tick();
    checks++; if (fifo_rd !== 1'b0) begin failures++; $display("FAIL single_rd_c2 got=%0h exp=0", fifo_rd); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL single_valid_c2 got=%0h exp=0", rx_valid); end
    tick();
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL single_valid_c3 got=%0h exp=1", rx_valid); end
    checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%0h exp=a5", rx_data); end
    repeat (5) tick();
    checks++; if (rd_pulses !== 1) begin failures++; $display("FAIL single_pulses got=%0d exp=1", rd_pulses); end
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL single_hold got=%0h exp=1", rx_valid); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL single_irq got=%0h exp=0", irq); end
    ack_byte();
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL single_acked got=%0h exp=0", rx_valid); end
  endtask

  task automatic test_back_to_back();
    int t = 0;
    int pulses0 = rd_pulses;
    for (int i = 0; i < 4; i++) push(8'(i + 1));
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      while (rx_valid !== 1'b1 && n < 12) begin tick(); t++; n++; end
      checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL burst_valid[%0d] got=%0h exp=1", i, rx_valid); end
      checks++; if (rx_data !== 8'(i + 1)) begin failures++; $display("FAIL burst_data[%0d] got=%0h exp=%0h", i, rx_data, i + 1); end
      checks++; if (t !== 3 + 4 * i) begin failures++; $display("FAIL burst_cycle[%0d] got=%0d exp=%0d", i, t, 3 + 4 * i); end
      ack_byte();
      t++;
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL burst_ack[%0d] got=%0h exp=0", i, rx_valid); end
    end
    repeat (2) tick();
    checks++; if (rd_pulses - pulses0 !== 4) begin failures++; $display("FAIL burst_pulses got=%0d exp=4", rd_pulses - pulses0); end
    checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL burst_empty got=%0h exp=1", fifo_empty); end
    checks++; if (dut.r_state !== StIdle) begin failures++; $display("FAIL burst_state got=%0h exp=%0h", dut.r_state, StIdle); end
  endtask

  task automatic test_timeout();
    push(8'h3C);
    repeat (3) tick();
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL to_valid got=%0h exp=1", rx_valid); end
    repeat (10) tick();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL to_irq_c13 got=%0h exp=0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL to_irq_c14 got=%0h exp=1", irq); end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL to_irq_cleared got=%0h exp=0", irq); end
    repeat (5) tick();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL to_no_retrigger got=%0h exp=0", irq); end
    ack_byte();
    tick();
  endtask

  task automatic test_threshold();
    fifo_threshold = 1'b1;
    tick();
    fifo_threshold = 1'b0;
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL thr_set got=%0h exp=1", irq); end
    fifo_threshold = 1'b1;
    irq_ack = 1'b1;
    tick();
    fifo_threshold = 1'b0;
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL thr_set_wins got=%0h exp=1", irq); end
    tick();
    irq_ack = 1'b0;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL thr_ack got=%0h exp=0", irq); end
  endtask

  task automatic test_underflow();
    fifo_underflow = 1'b1;
    tick();
    fifo_underflow = 1'b0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL uf_err got=%0h exp=1", err); end
    push(8'h42);
    repeat (3) tick();
    checks++; if (rx_data !== 8'h42) begin failures++; $display("FAIL uf_data got=%0h exp=42", rx_data); end
    ack_byte();
    tick();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL uf_sticky got=%0h exp=1", err); end
  endtask

  task automatic test_reset_mid();
    push(8'h5A);
    repeat (2) tick();
    rst = 1'b1;
    #1;
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%0h exp=0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL mid_data got=%0h exp=0", rx_data); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL mid_err got=%0h exp=0", err); end
    checks++; if (fifo_rd !== 1'b0) begin failures++; $display("FAIL mid_rd got=%0h exp=0", fifo_rd); end
    tick();
    rst = 1'b0;
    push(8'h77);
    repeat (3) tick();
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL mid_next_valid got=%0h exp=1", rx_valid); end
    checks++; if (rx_data !== 8'h77) begin failures++; $display("FAIL mid_next_data got=%0h exp=77", rx_data); end
    ack_byte();
    tick();
  endtask

  task automatic test_abort();
    int rd0;
    push(8'h99);
    tick();
    rd0 = rd_cnt;
    empty_force = 1'b1;
    #1;
    checks++; if (fifo_rd !== 1'b0) begin failures++; $display("FAIL abort_rd got=%0h exp=0", fifo_rd); end
    tick();
    empty_force = 1'b0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL abort_err got=%0h exp=1", err); end
    checks++; if (rd_cnt !== rd0) begin failures++; $display("FAIL abort_no_pop got=%0d exp=%0d", rd_cnt, rd0); end
    repeat (3) tick();
    checks++; if (rx_data !== 8'h99) begin failures++; $display("FAIL abort_retry got=%0h exp=99", rx_data); end
    ack_byte();
  endtask

  initial begin
    rst            = 1'b1;
    fifo_threshold = 1'b0;
    fifo_underflow = 1'b0;
    rx_ack         = 1'b0;
    irq_ack        = 1'b0;
    empty_force    = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_threshold();
    test_underflow();
    test_reset_mid();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
